// File: rtl/switch_conditioner_pkg.sv
// Board-wide constants shared by the ice40 projects, plus a counter sizing helper.
package switch_conditioner_pkg;

  localparam int CLK_HZ               = 12_000_000;
  localparam int CLKS_PER_MS          = CLK_HZ / 1000;
  localparam int DEBOUNCE_CYCLES      = 250_000;
  localparam int REPEAT_DELAY_CYCLES  = 6_000_000;
  localparam int REPEAT_PERIOD_CYCLES = 1_200_000;

  function automatic int counter_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/switch_conditioner_debounce_filter.sv
// Two-flop synchronizer and counter debounce; emits the filtered level and press/release pulses.
module debounce_filter
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic accept_press,
  output logic accept_release
);

  localparam int CNT_W = counter_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] count;
  logic             at_limit;

  // accept_* fire on the edge where the level flips, so the repeat FSM can act on that same edge
  assign at_limit       = (s2 != level) && (count == CNT_LAST);
  assign accept_press   = at_limit && s2;
  assign accept_release = at_limit && !s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      count         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      if (s2 == level) begin
        count <= '0;
      end else if (at_limit) begin
        count <= '0;
        level <= s2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Push-button conditioner: debounced level, press/release pulses and a hold-to-repeat pulse train.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD  = REPEAT_PERIOD_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } rep_state_t;

  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);
  localparam int REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W     = counter_width(REP_MAX);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  rep_state_t       state;
  rep_state_t       state_next;
  logic [REP_W-1:0] rep_count;
  logic             rep_clear;
  logic             repeat_fire;
  logic             repeat_q;
  logic             accept_press;
  logic             accept_release;

  debounce_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_filter (
    .clk           (i_Clk),
    .rst           (i_Rst),
    .raw           (i_Switch),
    .level         (o_Switch),
    .press_pulse   (o_Press),
    .release_pulse (o_Release),
    .accept_press  (accept_press),
    .accept_release(accept_release)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      rep_count <= '0;
      repeat_q  <= 1'b0;
    end else begin
      state     <= state_next;
      rep_count <= rep_clear ? '0 : rep_count + 1'b1;
      repeat_q  <= repeat_fire;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept_press && REPEAT_EN) state_next = HELD;
      HELD: begin
        if (accept_release)              state_next = IDLE;
        else if (rep_count == DELAY_LAST) state_next = REPEATING;
      end
      REPEATING: if (accept_release) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // A release landing on a due repeat wins: the counter clears and no pulse is issued
  always_comb begin
    repeat_fire = 1'b0;
    rep_clear   = 1'b0;
    case (state)
      HELD: begin
        if (accept_release) begin
          rep_clear = 1'b1;
        end else if (rep_count == DELAY_LAST) begin
          repeat_fire = 1'b1;
          rep_clear   = 1'b1;
        end
      end
      REPEATING: begin
        if (accept_release) begin
          rep_clear = 1'b1;
        end else if (rep_count == PERIOD_LAST) begin
          repeat_fire = 1'b1;
          rep_clear   = 1'b1;
        end
      end
      default: rep_clear = 1'b1;
    endcase
  end

  assign o_Repeat = REPEAT_EN ? repeat_q : 1'b0;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench: two conditioners (auto-repeat on and off) driven from one stimulus process.
module tb_switch_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sw_a, sw_b;
  logic level_a, press_a, release_a, repeat_a;
  logic level_b, press_b, release_b, repeat_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int press_cnt_a = 0, release_cnt_a = 0, press_cyc_a = 0, release_cyc_a = 0;
  int press_cnt_b = 0, release_cnt_b = 0, repeat_cnt_b = 0, press_cyc_b = 0;
  int overlap = 0;
  int repeat_log[$];

  switch_conditioner #(
    .DEBOUNCE_LIMIT(10),
    .REPEAT_DELAY  (40),
    .REPEAT_PERIOD (20)
  ) dut_a (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw_a),
    .o_Switch (level_a),
    .o_Press  (press_a),
    .o_Release(release_a),
    .o_Repeat (repeat_a)
  );

  switch_conditioner #(
    .DEBOUNCE_LIMIT(10),
    .REPEAT_DELAY  (0),
    .REPEAT_PERIOD (20)
  ) dut_b (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw_b),
    .o_Switch (level_b),
    .o_Press  (press_b),
    .o_Release(release_b),
    .o_Repeat (repeat_b)
  );

  // Inputs change and outputs are sampled on the falling edge; cyc counts falling edges.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (press_a)   begin press_cnt_a++;   press_cyc_a = cyc;   end
    if (release_a) begin release_cnt_a++; release_cyc_a = cyc; end
    if (repeat_a)  repeat_log.push_back(cyc);
    if (press_b)   begin press_cnt_b++;   press_cyc_b = cyc;   end
    if (release_b) release_cnt_b++;
    if (repeat_b)  repeat_cnt_b++;
    if (press_a && release_a) overlap++;
    if (press_a && repeat_a)  overlap++;
    if (press_b && release_b) overlap++;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int n);
    sw_a = a;
    sw_b = b;
    repeat (n) tick();
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // A level set at cycle c reaches s1 on the next rising edge; the pulse is seen at c+12.
  initial begin
    int start, last_rise, p, p2, p3, rs;
    rst  = 1'b1;
    sw_a = 1'b0;
    sw_b = 1'b0;
    repeat (3) tick();
    checkOutput("rst_level_a",   level_a,   0);
    checkOutput("rst_press_a",   press_a,   0);
    checkOutput("rst_release_a", release_a, 0);
    checkOutput("rst_repeat_a",  repeat_a,  0);
    checkOutput("rst_level_b",   level_b,   0);

    $display("[TB] clean press after reset");
    rst   = 1'b0;
    start = cyc;
    applyStimulus(1'b1, 1'b0, 11);
    checkOutput("t1_level_early", level_a, 0);
    checkOutput("t1_no_early_press", press_cnt_a, 0);
    tick();
    checkOutput("t1_level_up", level_a, 1);
    checkOutput("t1_press", press_a, 1);
    checkOutput("t1_release_low", release_a, 0);
    checkOutput("t1_press_latency", press_cyc_a - start, 12);
    tick();
    checkOutput("t1_press_width", press_a, 0);
    checkOutput("t1_press_count", press_cnt_a, 1);
    runTo(start + 15);
    start = cyc;
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("t1_release_count", release_cnt_a, 1);
    checkOutput("t1_release_latency", release_cyc_a - start, 12);
    checkOutput("t1_level_down", level_a, 0);
    checkOutput("t1_no_repeat", repeat_log.size(), 0);

    $display("[TB] bouncing input");
    last_rise = cyc;
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) last_rise = cyc;
      applyStimulus((i % 2) == 0, 1'b0, 4);
    end
    checkOutput("t2_no_press_bounce", press_cnt_a, 1);
    runTo(last_rise + 20);
    checkOutput("t2_one_press", press_cnt_a, 2);
    checkOutput("t2_press_latency", press_cyc_a - last_rise, 12);

    $display("[TB] auto-repeat while held");
    p = press_cyc_a;
    runTo(p + 120);
    checkOutput("t3_repeat_count", repeat_log.size(), 5);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("t3_repeat_%0d", k), repeat_log[k] - p, 40 + 20 * k);
    start = cyc;
    applyStimulus(1'b0, 1'b0, 40);
    checkOutput("t3_release_count", release_cnt_a, 2);
    checkOutput("t3_release_latency", release_cyc_a - start, 12);
    checkOutput("t3_no_repeat_after", repeat_log.size(), 5);

    $display("[TB] release on a due repeat edge");
    start = cyc;
    applyStimulus(1'b1, 1'b0, 12);
    checkOutput("t4_press_latency", press_cyc_a - start, 12);
    p2 = press_cyc_a;
    runTo(p2 + 48);
    sw_a = 1'b0;
    runTo(p2 + 60);
    checkOutput("t4_release_pulse", release_a, 1);
    checkOutput("t4_repeat_suppressed", repeat_a, 0);
    checkOutput("t4_repeat_count", repeat_log.size(), 6);
    checkOutput("t4_first_repeat", repeat_log[repeat_log.size() - 1] - p2, 40);
    applyStimulus(1'b0, 1'b0, 60);
    checkOutput("t4_idle_no_repeat", repeat_log.size(), 6);

    $display("[TB] auto-repeat disabled");
    start = cyc;
    applyStimulus(1'b0, 1'b1, 200);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("t5_press_count", press_cnt_b, 1);
    checkOutput("t5_release_count", release_cnt_b, 1);
    checkOutput("t5_repeat_count", repeat_cnt_b, 0);
    checkOutput("t5_press_latency", press_cyc_b - start, 12);

    $display("[TB] reset while repeating");
    start = cyc;
    applyStimulus(1'b1, 1'b0, 12);
    p3 = press_cyc_a;
    checkOutput("t6_press_latency", p3 - start, 12);
    runTo(p3 + 45);
    checkOutput("t6_repeating", repeat_log.size(), 7);
    rst = 1'b1;
    tick();
    checkOutput("t6_rst_level", level_a, 0);
    checkOutput("t6_rst_press", press_a, 0);
    checkOutput("t6_rst_release", release_a, 0);
    checkOutput("t6_rst_repeat", repeat_a, 0);
    rst = 1'b0;
    rs  = cyc;
    applyStimulus(1'b1, 1'b0, 12);
    checkOutput("t6_repress_latency", press_cyc_a - rs, 12);
    checkOutput("t6_no_release_on_reset", release_cnt_a, 3);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("t6_final_release", release_cnt_a, 4);
    checkOutput("t6_repeat_total", repeat_log.size(), 7);

    checkOutput("pulse_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
